lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit: the initiator side of the word-wide, single-port L1 data memory.
- Accepts one RV32I load/store request at a time from the core, with byte, halfword or word size.
- Drives the memory's address, write-data and write-enable lines and captures its read data, which is registered with 1-cycle latency.
- Returns a sign/zero-extended load result. Sub-word stores are done as read-modify-write, because the memory has no byte enables.

Parameters:
- N, 1024, data memory depth in 32-bit words; AW = $clog2(N) is derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign encoding
- req_addr  in  32  byte address
- req_wdata  in  32  store data, in the low bits for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and on errors
- resp_err  out  1  misaligned access or illegal funct3, valid with resp_valid
- mem_a  out  AW  word address to data memory
- mem_wd  out  32  write data to data memory
- mem_we  out  1  1 = write this cycle; 0 = read, with data returned on mem_rd next cycle
- mem_rd  in  32  registered read data from data memory

Behaviour:
- Reset (synchronous):
  - state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_we = 0, mem_a = 0, mem_wd = 0; req_ready = 1 after reset.
- Acceptance in cycle T latches store, funct3, addr and wdata.
  - Word address = addr[AW+1:2]; byte offset = addr[1:0].
  - addr[31:AW+2] is ignored, so addresses alias and wrap.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misalignment:
  - Halfword with offset[0] = 1.
  - Word with offset != 0.
- State sequences:
  - Error (misaligned or illegal): IDLE -> DONE. resp_valid = 1 and resp_err = 1 at T+1; no memory cycle; mem_we stays 0.
  - Load: IDLE -> RD -> MRG -> DONE.
    - RD (T+1): mem_a = word address, mem_we = 0.
    - MRG (T+2): mem_rd is valid; extract the lane selected by the offset, extend, and register into resp_rdata.
    - DONE (T+3): resp_valid = 1.
  - SW: IDLE -> WR -> DONE.
    - WR (T+1): mem_we = 1, mem_wd = wdata.
    - DONE (T+2): resp_valid = 1.
  - SB/SH: IDLE -> RD -> MRG -> DONE.
    - MRG (T+2): mem_we = 1, mem_wd = mem_rd with the addressed byte/halfword lane replaced by wdata[7:0] or wdata[15:0]; mem_a unchanged.
    - DONE (T+3): resp_valid = 1.
- Extraction and merge:
  - Byte lane k = bits [8k+7:8k]; halfword lane = bits [16*offset[1]+15 : 16*offset[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- DONE always returns to IDLE the next cycle.
  - resp_valid is exactly one cycle wide.
  - resp_rdata and resp_err hold until the next DONE.
- Outside IDLE:
  - req_ready = 0; req_valid is ignored, with no queueing.
  - mem_we = 1 only in WR, and in MRG for a sub-word store.
- In IDLE, mem_a holds its last value and mem_we = 0; reads issued in IDLE are harmless.
- Reset mid-operation:
  - Abort to IDLE; no response is issued.
  - If reset is asserted in RD of a sub-word store, no write occurs.
  - If reset is asserted in the same cycle as a write, that cycle's mem_we is forced to 0.
- Request in the same cycle as reset: ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101).
  - State encoding (IDLE, RD, MRG, WR, DONE).
- One combinational sub-module, lsu_align (inputs: word, offset, funct3, wdata; outputs: extended load value, merged store word, misaligned flag, illegal flag).
- The FSM and registers stay in lsu.

Test Plan:
- Preload mem word 5 = 0x8899AABB; LB at 0x16 -> resp_rdata = 0xFFFFFF99 at T+3; LBU -> 0x00000099; LH -> 0xFFFF8899; LHU at 0x14 -> 0x0000AABB.
- SB at 0x15 with wdata 0x123456CC -> mem_we = 1 at T+2 with mem_wd = 0x8899CCBB, resp_valid at T+3; a following LW at 0x14 returns 0x8899CCBB.
- SW at 0x14 with 0xDEADBEEF -> mem_we = 1 at T+1, mem_wd = 0xDEADBEEF, resp_valid at T+2, resp_err = 0.
- LW at 0x16 and SH at 0x17 -> resp_err = 1, resp_rdata = 0 at T+1, mem_we never 1; funct3 = 011 load -> same.
- Address wrap: N = 1024, SW at 0x00001014 -> mem_a = 5.
- Back-to-back: req_valid held high for two requests -> second accepted only in the cycle after DONE; req_ready = 0 in between.
- Reset in RD of SH at 0x14 -> no mem_we, no resp_valid; word 5 unchanged; req_ready = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// RV32I size/sign encodings and FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MRG  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction, sub-word store merge and
// access legality checks for the load/store unit.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic        store_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o,
    output logic        misal_o,
    output logic        illegal_o
);

    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] mask_b;
    logic [31:0] mask_h;
    logic [31:0] ins_b;
    logic [31:0] ins_h;

    // Extract/extend the addressed lane and build the merged store word
    always_comb begin
        sh_b   = word_i >> {off_i, 3'b000};
        sh_h   = word_i >> {off_i[1], 4'b0000};
        mask_b = 32'h0000_00FF << {off_i, 3'b000};
        mask_h = 32'h0000_FFFF << {off_i[1], 4'b0000};
        ins_b  = {24'd0, wdata_i[7:0]} << {off_i, 3'b000};
        ins_h  = {16'd0, wdata_i[15:0]} << {off_i[1], 4'b0000};
        load_o  = word_i;
        merge_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                load_o  = {{24{sh_b[7]}}, sh_b[7:0]};
                merge_o = (word_i & ~mask_b) | ins_b;
            end
            F3_BU: load_o = {24'd0, sh_b[7:0]};
            F3_H: begin
                load_o  = {{16{sh_h[15]}}, sh_h[15:0]};
                merge_o = (word_i & ~mask_h) | ins_h;
            end
            F3_HU: load_o = {16'd0, sh_h[15:0]};
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

    // Flag misaligned halfword/word accesses and unsupported encodings
    always_comb begin
        misal_o = ((funct3_i[1:0] == 2'b01) && off_i[0])
               || ((funct3_i[1:0] == 2'b10) && (off_i != 2'b00));
        if (store_i) begin
            illegal_o = !((funct3_i == F3_B) || (funct3_i == F3_H)
                       || (funct3_i == F3_W));
        end else begin
            illegal_o = !((funct3_i == F3_B) || (funct3_i == F3_H)
                       || (funct3_i == F3_W) || (funct3_i == F3_BU)
                       || (funct3_i == F3_HU));
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit driving a word-wide single-port data memory;
// sub-word stores are performed as read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter  int N  = 1024,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    state_e        state_q, state_d;
    logic          store_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          idle;
    logic          accept;
    logic          store_s;
    logic [2:0]    f3_s;
    logic [1:0]    off_s;
    logic [31:0]   load_v;
    logic [31:0]   merge_v;
    logic          misal;
    logic          illegal;
    logic          bad;
    logic          unused_addr;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && req_valid;

    // Legality is judged on the live request in IDLE, else on latched fields
    assign store_s = idle ? req_store       : store_q;
    assign f3_s    = idle ? req_funct3      : f3_q;
    assign off_s   = idle ? req_addr[1:0]   : off_q;
    assign bad     = misal || illegal;

    assign unused_addr = ^req_addr[31:AW+2];

    lsu_align u_align (
        .word_i    (mem_rd),
        .off_i     (off_s),
        .funct3_i  (f3_s),
        .store_i   (store_s),
        .wdata_i   (wdata_q),
        .load_o    (load_v),
        .merge_o   (merge_v),
        .misal_o   (misal),
        .illegal_o (illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad)
                        state_d = S_DONE;
                    else if (req_store && (req_funct3 == F3_W))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = S_MRG;
            S_MRG:   state_d = S_DONE;
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; any write is squashed while reset is asserted
    always_comb begin
        req_ready  = idle;
        resp_valid = (state_q == S_DONE);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_a      = addr_q;
        mem_we     = 1'b0;
        mem_wd     = 32'd0;
        if (state_q == S_WR) begin
            mem_we = !rst;
            mem_wd = wdata_q;
        end else if ((state_q == S_MRG) && store_q) begin
            mem_we = !rst;
            mem_wd = merge_v;
        end
    end

    // Request latch and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            wdata_q <= 32'd0;
            addr_q  <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                store_q <= req_store;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                wdata_q <= req_wdata;
                addr_q  <= req_addr[AW+1:2];
                if (bad) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b1;
                end
            end
            if (state_q == S_MRG) begin
                rdata_q <= store_q ? 32'd0 : load_v;
                err_q   <= 1'b0;
            end
            if (state_q == S_WR) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table,
// multi-cycle corner sequences and random vs byte-array model.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    lsu #(.N(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous write, registered read
    logic [31:0] dmem [0:1023];
    logic        clr;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
        end else if (mem_we) begin
            dmem[mem_a] <= mem_wd;
        end
        mem_rd <= dmem[mem_a];
    end

    // Reference memory as a flat little-endian byte array
    logic [7:0] ref_b [0:4095];

    int npass;
    int ncheck;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        ncheck++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", n, act, exp);
    endtask

    task automatic model(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat);
        int b;
        int sz;
        bit legal;
        logic [31:0] v;
        b  = int'(a[11:0]);
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        er = !legal || ((b % sz) != 0);
        rd = 32'd0;
        if (er) begin
            lat = 1;
        end else if (st) begin
            for (int i = 0; i < sz; i++) ref_b[b+i] = wd[8*i +: 8];
            lat = (sz == 4) ? 2 : 3;
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v = v | (32'(ref_b[b+i]) << (8*i));
            if (!f3[2] && sz < 4 && v[8*sz-1])
                v = v | (32'hFFFF_FFFF << (8*sz));
            rd  = v;
            lat = 3;
        end
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int nwe,
                           output logic [31:0] lwd, output logic [9:0] lwa);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nwe = 0; rd = 32'hx; er = 1'bx; lwd = 32'd0; lwa = 10'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) begin
                nwe++;
                lwd = mem_wd;
                lwa = mem_a;
            end
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nwe;
        logic [31:0] wdv;
        logic [9:0]  wa;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] rd, erd, lwd;
        logic [9:0]  lwa;
        logic        er, eer;
        int          lat, elat, nwe;
        int          ready_bad;
        int          rv_cyc [$];
        logic [31:0] rv_dat [$];
        logic [31:0] exp1, exp2;
        logic        we_seen, rv_seen;
        logic        rs, ew;
        logic [2:0]  rf;
        logic [31:0] ra, rw;
        int          bad_words;
        logic [31:0] w;

        npass = 0;
        ncheck = 0;
        for (int i = 0; i < 4096; i++) ref_b[i] = 8'd0;

        rst = 1'b1; clr = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b0; clr = 1'b0;

        tbl[0]  = '{1'b1, 3'd2, 32'h14, 32'h8899AABB, 32'h0, 1'b0, 2, 1, 32'h8899AABB, 10'd5};
        tbl[1]  = '{1'b0, 3'd0, 32'h16, 32'h0, 32'hFFFFFF99, 1'b0, 3, 0, 32'h0, 10'd0};
        tbl[2]  = '{1'b0, 3'd4, 32'h16, 32'h0, 32'h00000099, 1'b0, 3, 0, 32'h0, 10'd0};
        tbl[3]  = '{1'b0, 3'd1, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 32'h0, 10'd0};
        tbl[4]  = '{1'b0, 3'd5, 32'h14, 32'h0, 32'h0000AABB, 1'b0, 3, 0, 32'h0, 10'd0};
        tbl[5]  = '{1'b1, 3'd0, 32'h15, 32'h123456CC, 32'h0, 1'b0, 3, 1, 32'h8899CCBB, 10'd5};
        tbl[6]  = '{1'b0, 3'd2, 32'h14, 32'h0, 32'h8899CCBB, 1'b0, 3, 0, 32'h0, 10'd0};
        tbl[7]  = '{1'b1, 3'd2, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF, 10'd5};
        tbl[8]  = '{1'b0, 3'd2, 32'h16, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 10'd0};
        tbl[9]  = '{1'b1, 3'd1, 32'h17, 32'h1234, 32'h0, 1'b1, 1, 0, 32'h0, 10'd0};
        tbl[10] = '{1'b0, 3'd3, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 10'd0};
        tbl[11] = '{1'b1, 3'd2, 32'h1014, 32'h11223344, 32'h0, 1'b0, 2, 1, 32'h11223344, 10'd5};
        tbl[12] = '{1'b0, 3'd2, 32'h14, 32'h0, 32'h11223344, 1'b0, 3, 0, 32'h0, 10'd0};
        tbl[13] = '{1'b1, 3'd1, 32'h16, 32'hAAAA5555, 32'h0, 1'b0, 3, 1, 32'h55553344, 10'd5};
        tbl[14] = '{1'b0, 3'd0, 32'h14, 32'h0, 32'h00000044, 1'b0, 3, 0, 32'h0, 10'd0};

        foreach (tbl[i]) begin
            model(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, erd, eer, elat);
            run_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
                    rd, er, lat, nwe, lwd, lwa);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].er));
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_nwe", i), nwe, tbl[i].nwe);
            if (tbl[i].nwe != 0) begin
                chk($sformatf("vec%0d_wd", i), lwd, tbl[i].wdv);
                chk($sformatf("vec%0d_wa", i), 32'(lwa), 32'(tbl[i].wa));
            end
        end

        // Back-to-back: req_valid held high across two requests
        model(1'b0, 3'd2, 32'h14, 32'h0, exp1, eer, elat);
        model(1'b0, 3'd4, 32'h15, 32'h0, exp2, eer, elat);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0;
        req_funct3 = 3'd2; req_addr = 32'h14;
        ready_bad = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                req_funct3 = 3'd4;
                req_addr = 32'h15;
            end
            if (c == 5) req_valid = 1'b0;
            @(negedge clk);
            if (resp_valid) begin
                rv_cyc.push_back(c);
                rv_dat.push_back(resp_rdata);
            end
            if (c == 4) chk("b2b_ready_after_done", 32'(req_ready), 32'd1);
            else if (c != 8 && req_ready) ready_bad++;
        end
        chk("b2b_ready_low", ready_bad, 0);
        chk("b2b_nresp", rv_cyc.size(), 2);
        if (rv_cyc.size() == 2) begin
            chk("b2b_first_cyc", rv_cyc[0], 3);
            chk("b2b_second_cyc", rv_cyc[1], 7);
            chk("b2b_first_data", rv_dat[0], exp1);
            chk("b2b_second_data", rv_dat[1], exp2);
        end

        // Reset during RD of a halfword store
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd1;
        req_addr = 32'h14; req_wdata = 32'h0000_7777;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        we_seen = mem_we; rv_seen = resp_valid;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstrd_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            we_seen |= mem_we; rv_seen |= resp_valid;
            @(negedge clk);
        end
        chk("rstrd_no_we", 32'(we_seen), 32'd0);
        chk("rstrd_no_resp", 32'(rv_seen), 32'd0);
        model(1'b0, 3'd2, 32'h14, 32'h0, erd, eer, elat);
        run_req(1'b0, 3'd2, 32'h14, 32'h0, rd, er, lat, nwe, lwd, lwa);
        chk("rstrd_word5", rd, erd);

        // Reset coinciding with the write cycle of a word store
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h18; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstwr_we_forced", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rv_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rv_seen |= resp_valid;
        end
        chk("rstwr_no_resp", 32'(rv_seen), 32'd0);
        model(1'b0, 3'd2, 32'h18, 32'h0, erd, eer, elat);
        run_req(1'b0, 3'd2, 32'h18, 32'h0, rd, er, lat, nwe, lwd, lwa);
        chk("rstwr_word6", rd, erd);

        // Random traffic against the byte-array model
        for (int n = 0; n < 300; n++) begin
            rs = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            rw = $urandom;
            model(rs, rf, ra, rw, erd, eer, elat);
            ew = rs && !eer;
            run_req(rs, rf, ra, rw, rd, er, lat, nwe, lwd, lwa);
            chk($sformatf("rnd%0d_rdata", n), rd, erd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(eer));
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            chk($sformatf("rnd%0d_nwe", n), nwe, ew ? 1 : 0);
        end

        // Memory image versus model
        @(negedge clk);
        bad_words = 0;
        for (int i = 0; i < 1024; i++) begin
            w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
            if (dmem[i] !== w) bad_words++;
        end
        chk("mem_image", bad_words, 0);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
